rtc_access_sequencer: RTL

Command-level sequencer sitting directly upstream of the RTC bus-timing FSM (`transfer`). Two operations: on a periodic `tick` it performs a burst read of the RTC time registers; on `wr_req` it performs a single-register write. For each access it drives `Acceso`/`read` into `transfer`, monitors the returned `AD`/`CS`/`RD`/`WR`/`FRW`, and drives or samples the multiplexed 8-bit address/data bus. It then publishes a coherent time snapshot to the display/interface logic.

---
 rtl/rtc_access_sequencer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/rtc_access_sequencer.sv
// Command sequencer in front of the RTC bus-timing FSM: burst-reads the time registers on tick,
// performs single-register writes on request, and publishes a coherent time snapshot.
module rtc_access_sequencer #(
    parameter logic [7:0] ADDR_BASE = 8'h21,
    parameter int         NUM_REGS  = 6,
    parameter int         TIMEOUT   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       AD,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    input  logic       FRW,
    input  logic [7:0] bus_in,
    output logic       Acceso,
    output logic       read,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic       data_valid,
    output logic       busy,
    output logic       err
);

    localparam int         NUM_OUT     = 6;
    localparam logic [2:0] LAST_INDEX  = 3'(NUM_REGS - 1);
    localparam logic [6:0] TIMEOUT_CNT = 7'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, NEXT} state_t;

    state_t      state_reg, state_next;
    logic        wr_pend_reg, tick_pend_reg;
    logic [7:0]  wr_addr_reg, wr_data_reg;
    logic [7:0]  addr_reg, addr_next;
    logic [7:0]  data_reg, data_next;
    logic        op_read_reg, op_read_next;
    logic [2:0]  index_reg, index_next;
    logic [6:0]  wait_cnt_reg;
    logic        frw_prev_reg;
    logic        err_reg;
    logic        data_valid_reg;

    logic        take_wr, take_tick, restart_cnt, set_err, clr_err, publish;
    logic        timed_out, frw_rise, read_capture;

    assign timed_out    = (wait_cnt_reg >= TIMEOUT_CNT);
    assign frw_rise     = FRW && !frw_prev_reg;
    // RD can float; only a solid 0 counts as an active read strobe.
    assign read_capture = (state_reg == WAIT) && !CS && (RD == 1'b0) && AD;

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        op_read_next = op_read_reg;
        index_next   = index_reg;
        take_wr      = 1'b0;
        take_tick    = 1'b0;
        restart_cnt  = 1'b0;
        set_err      = 1'b0;
        clr_err      = 1'b0;
        publish      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (wr_pend_reg) begin
                    take_wr      = 1'b1;
                    addr_next    = wr_addr_reg;
                    data_next    = wr_data_reg;
                    op_read_next = 1'b0;
                    restart_cnt  = 1'b1;
                    state_next   = ISSUE;
                end else if (tick_pend_reg) begin
                    take_tick    = 1'b1;
                    index_next   = 3'd0;
                    addr_next    = ADDR_BASE;
                    op_read_next = 1'b1;
                    restart_cnt  = 1'b1;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                // Leaving ISSUE drops Acceso so transfer cannot re-trigger when it returns idle.
                if (!CS) begin
                    state_next = WAIT;
                end else if (timed_out) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (frw_rise) begin
                    state_next = NEXT;
                end else if (timed_out) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            NEXT: begin
                clr_err    = 1'b1;
                state_next = IDLE;
                if (op_read_reg) begin
                    if (index_reg < LAST_INDEX) begin
                        index_next  = index_reg + 3'd1;
                        addr_next   = addr_reg + 8'd1;
                        restart_cnt = 1'b1;
                        state_next  = ISSUE;
                    end else begin
                        publish = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            wr_pend_reg    <= 1'b0;
            tick_pend_reg  <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            addr_reg       <= '0;
            data_reg       <= '0;
            op_read_reg    <= 1'b0;
            index_reg      <= '0;
            wait_cnt_reg   <= '0;
            frw_prev_reg   <= 1'b0;
            err_reg        <= 1'b0;
            data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            op_read_reg    <= op_read_next;
            index_reg      <= index_next;
            frw_prev_reg   <= FRW;
            data_valid_reg <= publish;

            // A fresh request in the consuming cycle stays pending for the next round.
            if (wr_req) begin
                wr_pend_reg <= 1'b1;
                wr_addr_reg <= wr_addr;
                wr_data_reg <= wr_data;
            end else if (take_wr) begin
                wr_pend_reg <= 1'b0;
            end

            if (tick) begin
                tick_pend_reg <= 1'b1;
            end else if (take_tick) begin
                tick_pend_reg <= 1'b0;
            end

            if (restart_cnt) begin
                wait_cnt_reg <= '0;
            end else if ((state_reg == ISSUE || state_reg == WAIT) && wait_cnt_reg != 7'h7F) begin
                wait_cnt_reg <= wait_cnt_reg + 7'd1;
            end

            if (set_err) begin
                err_reg <= 1'b1;
            end else if (clr_err) begin
                err_reg <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_shadow
            logic [7:0] value_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    value_reg <= '0;
                end else if (read_capture && index_reg == 3'(gi)) begin
                    value_reg <= bus_in;
                end
            end
        end

        for (gi = 0; gi < NUM_OUT; gi++) begin : g_time
            logic [7:0] value_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    value_reg <= '0;
                end else if (publish) begin
                    value_reg <= g_shadow[gi].value_reg;
                end
            end
        end
    endgenerate

    always_comb begin
        bus_oe  = 1'b0;
        bus_out = 8'h00;
        if (state_reg == WAIT && !CS) begin
            if (!AD) begin
                bus_oe  = 1'b1;
                bus_out = addr_reg;
            end else if (!op_read_reg && !WR) begin
                bus_oe  = 1'b1;
                bus_out = data_reg;
            end
        end
    end

    assign Acceso     = (state_reg == ISSUE);
    assign read       = (state_reg == ISSUE) && op_read_reg;
    assign busy       = (state_reg != IDLE);
    assign err        = err_reg;
    assign data_valid = data_valid_reg;
    assign seg        = g_time[0].value_reg;
    assign min        = g_time[1].value_reg;
    assign hora       = g_time[2].value_reg;
    assign dia        = g_time[3].value_reg;
    assign mes        = g_time[4].value_reg;
    assign anio       = g_time[5].value_reg;

endmodule
